msrv32_machine_csr_file: RTL and testbench

Machine-mode CSR file for the msrv32 core. It is the receiving end of the machine-control interface: it consumes trap, retire and MIE-control strobes and returns the interrupt-enable and interrupt-pending bits. It holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause and mtval, plus the 64-bit mcycle/minstret counters. It executes Zicsr read/write/set/clear operations from pipeline stage 2, and supplies the trap vector and return address to the PC mux.

---
 rtl/msrv32_machine_csr_file_if.sv | 48 ++++
 rtl/msrv32_machine_csr_file.sv | 171 +++++++++++++++++
 tb/tb_msrv32_machine_csr_file.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/msrv32_machine_csr_file_if.sv
// Machine-control / stage-2 bus into the machine CSR file.
// The slave modport is the CSR file; master is the control unit and machine-control side.
interface msrv32_machine_csr_file_if;
    logic        wr_en_in;
    logic [11:0] csr_addr_in;
    logic [2:0]  funct3_in;
    logic [31:0] rs1_in;
    logic [4:0]  zimm_in;
    logic [31:0] pc_in;
    logic [31:0] iadder_in;
    logic        e_irq_in;
    logic        t_irq_in;
    logic        s_irq_in;
    logic        i_or_e_in;
    logic        set_epc_in;
    logic        set_cause_in;
    logic [3:0]  cause_in;
    logic        instret_inc_in;
    logic        mie_clear_in;
    logic        mie_set_in;
    logic        misaligned_exception_in;
    logic [31:0] csr_data_out;
    logic        mie_out;
    logic        meie_out;
    logic        mtie_out;
    logic        msie_out;
    logic        meip_out;
    logic        mtip_out;
    logic        msip_out;
    logic [31:0] epc_out;
    logic [31:0] trap_address_out;

    modport slave (
        input  wr_en_in, csr_addr_in, funct3_in, rs1_in, zimm_in, pc_in, iadder_in,
               e_irq_in, t_irq_in, s_irq_in, i_or_e_in, set_epc_in, set_cause_in,
               cause_in, instret_inc_in, mie_clear_in, mie_set_in, misaligned_exception_in,
        output csr_data_out, mie_out, meie_out, mtie_out, msie_out, meip_out,
               mtip_out, msip_out, epc_out, trap_address_out
    );

    modport master (
        output wr_en_in, csr_addr_in, funct3_in, rs1_in, zimm_in, pc_in, iadder_in,
               e_irq_in, t_irq_in, s_irq_in, i_or_e_in, set_epc_in, set_cause_in,
               cause_in, instret_inc_in, mie_clear_in, mie_set_in, misaligned_exception_in,
        input  csr_data_out, mie_out, meie_out, mtie_out, msie_out, meip_out,
               mtip_out, msip_out, epc_out, trap_address_out
    );
endinterface

// File: rtl/msrv32_machine_csr_file.sv
// Machine-mode CSR file: Zicsr access, trap capture, MIE stacking, mip sampling
// and the 64-bit mcycle/minstret counters.
module msrv32_machine_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MHARTID     = 32'd0
) (
    input logic                          clk_in,
    input logic                          reset_n_in,
    msrv32_machine_csr_file_if.slave     csr
);
    localparam logic [11:0] A_MSTATUS  = 12'h300, A_MISA    = 12'h301, A_MIE     = 12'h304,
                            A_MTVEC    = 12'h305, A_MSCRATCH = 12'h340, A_MEPC   = 12'h341,
                            A_MCAUSE   = 12'h342, A_MTVAL   = 12'h343, A_MIP     = 12'h344,
                            A_MCYCLE   = 12'hB00, A_MINSTRET = 12'hB02, A_MCYCLEH = 12'hB80,
                            A_MINSTRETH = 12'hB82, A_CYCLE  = 12'hC00, A_TIME    = 12'hC01,
                            A_INSTRET  = 12'hC02, A_CYCLEH  = 12'hC80, A_TIMEH   = 12'hC81,
                            A_INSTRETH = 12'hC82, A_MVENDOR = 12'hF11, A_MARCH   = 12'hF12,
                            A_MIMP     = 12'hF13, A_MHARTID = 12'hF14;

    logic        mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic        meie_q, meie_d, mtie_q, mtie_d, msie_q, msie_d;
    logic        meip_q, mtip_q, msip_q;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mtval_q, mtval_d;
    logic        mcause_int_q, mcause_int_d;
    logic [3:0]  mcause_code_q, mcause_code_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d, mcycle_inc, minstret_inc;

    logic [31:0] rdata, wsrc, wnew;
    logic        wr_commit;

    assign mcycle_inc   = mcycle_q + 64'd1;
    assign minstret_inc = minstret_q + {63'd0, csr.instret_inc_in};

    always_comb begin
        rdata = 32'd0;
        case (csr.csr_addr_in)
            A_MSTATUS:              rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            A_MISA:                 rdata = 32'h4000_0100;
            A_MIE:                  rdata = {20'd0, meie_q, 3'd0, mtie_q, 3'd0, msie_q, 3'd0};
            A_MIP:                  rdata = {20'd0, meip_q, 3'd0, mtip_q, 3'd0, msip_q, 3'd0};
            A_MTVEC:                rdata = {mtvec_q[31:2], 1'b0, mtvec_q[0]};
            A_MSCRATCH:             rdata = mscratch_q;
            A_MEPC:                 rdata = {mepc_q[31:2], 2'b00};
            A_MCAUSE:               rdata = {mcause_int_q, 27'd0, mcause_code_q};
            A_MTVAL:                rdata = mtval_q;
            A_MCYCLE, A_CYCLE, A_TIME:       rdata = mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH, A_TIMEH:    rdata = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:           rdata = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH:         rdata = minstret_q[63:32];
            A_MVENDOR, A_MARCH, A_MIMP:      rdata = 32'd0;
            A_MHARTID:              rdata = MHARTID;
            default:                rdata = 32'd0;
        endcase
    end

    // Read-modify-write operand is the architectural read value of the addressed CSR.
    assign wsrc      = csr.funct3_in[2] ? {27'd0, csr.zimm_in} : csr.rs1_in;
    assign wr_commit = csr.wr_en_in && (csr.funct3_in[1:0] != 2'b00);

    always_comb begin
        case (csr.funct3_in[1:0])
            2'b01:   wnew = wsrc;
            2'b10:   wnew = rdata | wsrc;
            2'b11:   wnew = rdata & ~wsrc;
            default: wnew = rdata;
        endcase
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        meie_d         = meie_q;
        mtie_d         = mtie_q;
        msie_d         = msie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_int_d   = mcause_int_q;
        mcause_code_d  = mcause_code_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_inc;
        minstret_d     = minstret_inc;

        if (wr_commit) begin
            case (csr.csr_addr_in)
                A_MSTATUS:   begin mstatus_mie_d = wnew[3]; mstatus_mpie_d = wnew[7]; end
                A_MIE:       begin meie_d = wnew[11]; mtie_d = wnew[7]; msie_d = wnew[3]; end
                A_MTVEC:     mtvec_d = {wnew[31:2], 1'b0, wnew[0]};
                A_MSCRATCH:  mscratch_d = wnew;
                A_MEPC:      mepc_d = {wnew[31:2], 2'b00};
                A_MCAUSE:    begin mcause_int_d = wnew[31]; mcause_code_d = wnew[3:0]; end
                A_MTVAL:     mtval_d = wnew;
                A_MCYCLE:    mcycle_d   = {mcycle_inc[63:32], wnew};
                A_MCYCLEH:   mcycle_d   = {wnew, mcycle_inc[31:0]};
                A_MINSTRET:  minstret_d = {minstret_inc[63:32], wnew};
                A_MINSTRETH: minstret_d = {wnew, minstret_inc[31:0]};
                default: ;
            endcase
        end

        // Machine-control updates are applied last so they override a same-cycle CSR write.
        if (csr.mie_clear_in) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (csr.mie_set_in) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        if (csr.set_epc_in)
            mepc_d = {csr.pc_in[31:2], 2'b00};
        if (csr.set_cause_in) begin
            mcause_int_d  = csr.i_or_e_in;
            mcause_code_d = csr.cause_in;
            mtval_d       = csr.misaligned_exception_in ? csr.iadder_in : 32'd0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            meie_q         <= 1'b0;
            mtie_q         <= 1'b0;
            msie_q         <= 1'b0;
            meip_q         <= 1'b0;
            mtip_q         <= 1'b0;
            msip_q         <= 1'b0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= 32'd0;
            mepc_q         <= 32'd0;
            mcause_int_q   <= 1'b0;
            mcause_code_q  <= 4'd0;
            mtval_q        <= 32'd0;
            mcycle_q       <= 64'd0;
            minstret_q     <= 64'd0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            meie_q         <= meie_d;
            mtie_q         <= mtie_d;
            msie_q         <= msie_d;
            meip_q         <= csr.e_irq_in;
            mtip_q         <= csr.t_irq_in;
            msip_q         <= csr.s_irq_in;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_int_q   <= mcause_int_d;
            mcause_code_q  <= mcause_code_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

    always_comb begin
        csr.trap_address_out = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[0] && csr.i_or_e_in)
            csr.trap_address_out = {mtvec_q[31:2], 2'b00} + {26'd0, csr.cause_in, 2'b00};
    end

    assign csr.csr_data_out = rdata;
    assign csr.mie_out      = mstatus_mie_q;
    assign csr.meie_out     = meie_q;
    assign csr.mtie_out     = mtie_q;
    assign csr.msie_out     = msie_q;
    assign csr.meip_out     = meip_q;
    assign csr.mtip_out     = mtip_q;
    assign csr.msip_out     = msip_q;
    assign csr.epc_out      = {mepc_q[31:2], 2'b00};
endmodule

// File: tb/tb_msrv32_machine_csr_file.sv
// Directed bench for msrv32_machine_csr_file: CSR access table plus trap,
// interrupt and counter sequences.
module tb_msrv32_machine_csr_file;
    logic clk, rst_n;
    int checks = 0;
    int errors = 0;

    msrv32_machine_csr_file_if bus();

    msrv32_machine_csr_file #(.MTVEC_RESET(32'h100), .MHARTID(32'h5)) dut (
        .clk_in(clk), .reset_n_in(rst_n), .csr(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic [11:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [2:0] f3, logic [11:0] addr, logic [31:0] rs1,
                                logic [4:0] zimm, logic [11:0] raddr, logic [31:0] exp, string name);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.rs1 = rs1; v.zimm = zimm;
        v.raddr = raddr; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(string name, logic [11:0] a, logic [31:0] exp);
        bus.csr_addr_in = a;
        #1;
        check(name, bus.csr_data_out, exp);
    endtask

    // Drive one CSR op from the next negedge; it commits on the following posedge.
    task automatic op(logic wr, logic [2:0] f3, logic [11:0] a, logic [31:0] rs1, logic [4:0] zimm);
        @(negedge clk);
        bus.wr_en_in = wr; bus.funct3_in = f3; bus.csr_addr_in = a;
        bus.rs1_in = rs1; bus.zimm_in = zimm;
        @(posedge clk);
        #1;
        bus.wr_en_in = 1'b0; bus.funct3_in = 3'b000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_en_in = 0; bus.csr_addr_in = 0; bus.funct3_in = 0; bus.rs1_in = 0;
        bus.zimm_in = 0; bus.pc_in = 0; bus.iadder_in = 0; bus.e_irq_in = 0;
        bus.t_irq_in = 0; bus.s_irq_in = 0; bus.i_or_e_in = 0; bus.set_epc_in = 0;
        bus.set_cause_in = 0; bus.cause_in = 0; bus.instret_inc_in = 0;
        bus.mie_clear_in = 0; bus.mie_set_in = 0; bus.misaligned_exception_in = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;

        rd("rst_mtvec", 12'h305, 32'h100);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mcycle", 12'hB00, 32'd0);
        rd("rst_mcycleh", 12'hB80, 32'd0);
        rd("rst_minstret", 12'hB02, 32'd0);
        rd("rst_mepc", 12'h341, 32'd0);
        check("rst_mie_out", {31'd0, bus.mie_out}, 32'd0);
        check("rst_trap_addr", bus.trap_address_out, 32'h100);
        check("rst_epc_out", bus.epc_out, 32'd0);

        @(negedge clk) rst_n = 1'b1;

        vecs.push_back(mk(1, 3'b001, 12'h340, 32'hDEAD_BEEF, 0, 12'h340, 32'hDEAD_BEEF, "csrrw_mscratch"));
        vecs.push_back(mk(1, 3'b110, 12'h340, 32'h0, 5'h10, 12'h340, 32'hDEAD_BEFF, "csrrsi_mscratch"));
        vecs.push_back(mk(1, 3'b011, 12'h340, 32'h0000_000F, 0, 12'h340, 32'hDEAD_BEF0, "csrrc_mscratch"));
        vecs.push_back(mk(1, 3'b000, 12'h340, 32'h0, 0, 12'h340, 32'hDEAD_BEF0, "funct3_none"));
        vecs.push_back(mk(0, 3'b001, 12'h340, 32'h0, 0, 12'h340, 32'hDEAD_BEF0, "wr_en_low"));
        vecs.push_back(mk(1, 3'b001, 12'h305, 32'hFFFF_FFFF, 0, 12'h305, 32'hFFFF_FFFD, "mtvec_warl"));
        vecs.push_back(mk(1, 3'b001, 12'h341, 32'hFFFF_FFFF, 0, 12'h341, 32'hFFFF_FFFC, "mepc_warl"));
        vecs.push_back(mk(1, 3'b001, 12'h344, 32'hFFFF_FFFF, 0, 12'h344, 32'h0, "mip_ro"));
        vecs.push_back(mk(1, 3'b001, 12'h304, 32'hFFFF_FFFF, 0, 12'h304, 32'h0000_0888, "mie_rw"));
        vecs.push_back(mk(1, 3'b111, 12'h304, 32'h0, 5'h08, 12'h304, 32'h0000_0880, "mie_rci"));
        vecs.push_back(mk(1, 3'b001, 12'h342, 32'h8000_000B, 0, 12'h342, 32'h8000_000B, "mcause_rw"));
        vecs.push_back(mk(1, 3'b001, 12'h343, 32'h1234_5678, 0, 12'h343, 32'h1234_5678, "mtval_rw"));
        vecs.push_back(mk(1, 3'b001, 12'hF11, 32'hFFFF_FFFF, 0, 12'hF11, 32'h0, "mvendorid_ro"));
        vecs.push_back(mk(1, 3'b001, 12'h7C0, 32'hFFFF_FFFF, 0, 12'h7C0, 32'h0, "unmapped"));
        vecs.push_back(mk(1, 3'b001, 12'h301, 32'h0, 0, 12'h301, 32'h4000_0100, "misa"));
        vecs.push_back(mk(1, 3'b001, 12'hF14, 32'h0, 0, 12'hF14, 32'h5, "mhartid"));
        vecs.push_back(mk(1, 3'b001, 12'h300, 32'hFFFF_FFFF, 0, 12'h300, 32'h0000_1888, "mstatus_rw"));
        vecs.push_back(mk(1, 3'b011, 12'h300, 32'hFFFF_FFFF, 0, 12'h300, 32'h0000_1800, "mstatus_rc"));
        vecs.push_back(mk(1, 3'b001, 12'hC02, 32'hFFFF_FFFF, 0, 12'hC02, 32'h0, "instret_ro"));
        vecs.push_back(mk(1, 3'b001, 12'hB02, 32'h7, 0, 12'hC02, 32'h7, "minstret_alias"));
        vecs.push_back(mk(1, 3'b001, 12'hB82, 32'h2, 0, 12'hC82, 32'h2, "minstreth_alias"));

        foreach (vecs[i]) begin
            op(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].zimm);
            rd(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end

        // Vectored trap address
        op(1, 3'b001, 12'h305, 32'h201, 0);
        bus.i_or_e_in = 1; bus.cause_in = 4'd7; #1;
        check("trap_vec_irq", bus.trap_address_out, 32'h21C);
        bus.i_or_e_in = 0; bus.cause_in = 4'd2; #1;
        check("trap_vec_exc", bus.trap_address_out, 32'h200);

        // Timer interrupt sampled with one cycle of latency
        op(1, 3'b001, 12'h304, 32'h80, 0);
        op(1, 3'b110, 12'h300, 32'h0, 5'h08);
        @(negedge clk) bus.t_irq_in = 1; #1;
        check("mtip_before", {31'd0, bus.mtip_out}, 32'd0);
        step();
        check("mtip_after", {31'd0, bus.mtip_out}, 32'd1);
        check("mtie_out", {31'd0, bus.mtie_out}, 32'd1);
        check("mie_out_set", {31'd0, bus.mie_out}, 32'd1);
        rd("mip_read", 12'h344, 32'h80);
        @(negedge clk) bus.t_irq_in = 0;

        // Misaligned trap entry with a colliding mepc write
        @(negedge clk);
        bus.pc_in = 32'h1002; bus.iadder_in = 32'h1002; bus.cause_in = 4'd0; bus.i_or_e_in = 0;
        bus.set_epc_in = 1; bus.set_cause_in = 1; bus.misaligned_exception_in = 1; bus.mie_clear_in = 1;
        bus.wr_en_in = 1; bus.funct3_in = 3'b001; bus.csr_addr_in = 12'h341; bus.rs1_in = 32'h5550;
        step();
        bus.set_epc_in = 0; bus.set_cause_in = 0; bus.misaligned_exception_in = 0;
        bus.mie_clear_in = 0; bus.wr_en_in = 0; bus.funct3_in = 0;
        rd("trap_mepc", 12'h341, 32'h1000);
        check("trap_epc_out", bus.epc_out, 32'h1000);
        rd("trap_mtval", 12'h343, 32'h1002);
        rd("trap_mcause", 12'h342, 32'h0);
        rd("trap_mstatus", 12'h300, 32'h1880);
        check("trap_mie_out", {31'd0, bus.mie_out}, 32'd0);

        @(negedge clk) bus.mie_set_in = 1;
        step();
        bus.mie_set_in = 0;
        rd("mret_mstatus", 12'h300, 32'h1888);

        // Interrupt cause clears mtval
        @(negedge clk);
        bus.set_cause_in = 1; bus.i_or_e_in = 1; bus.cause_in = 4'd7;
        step();
        bus.set_cause_in = 0; bus.i_or_e_in = 0;
        rd("irq_mcause", 12'h342, 32'h8000_0007);
        rd("irq_mtval", 12'h343, 32'h0);

        // mie_clear beats a same-cycle mstatus write
        @(negedge clk);
        bus.mie_clear_in = 1; bus.wr_en_in = 1; bus.funct3_in = 3'b110;
        bus.csr_addr_in = 12'h300; bus.zimm_in = 5'h08;
        step();
        bus.mie_clear_in = 0; bus.wr_en_in = 0; bus.funct3_in = 0;
        rd("collide_mstatus", 12'h300, 32'h1880);

        // mie_clear beats mie_set
        @(negedge clk);
        bus.mie_clear_in = 1; bus.mie_set_in = 1;
        step();
        bus.mie_clear_in = 0; bus.mie_set_in = 0;
        rd("clr_over_set", 12'h300, 32'h1800);

        // mcycle half writes against carry
        op(1, 3'b001, 12'hB80, 32'h5, 0);
        op(1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 0);
        rd("mcyc_lo_ff", 12'hB00, 32'hFFFF_FFFF);
        rd("mcyc_hi_5", 12'hB80, 32'h5);
        op(1, 3'b001, 12'hB00, 32'h10, 0);
        rd("mcyc_lo_wr_carry_lo", 12'hB00, 32'h10);
        rd("mcyc_lo_wr_carry_hi", 12'hB80, 32'h6);
        op(1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 0);
        op(1, 3'b001, 12'hB80, 32'h9, 0);
        rd("mcyc_hi_wr_lo", 12'hB00, 32'h0);
        rd("mcyc_hi_wr_hi", 12'hB80, 32'h9);
        op(1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 0);
        step();
        rd("mcyc_carry_lo", 12'hC00, 32'h0);
        rd("mcyc_carry_hi", 12'hC80, 32'hA);
        op(1, 3'b001, 12'hB80, 32'hFFFF_FFFF, 0);
        op(1, 3'b001, 12'hB00, 32'hFFFF_FFFF, 0);
        step();
        rd("mcyc_wrap_lo", 12'hB00, 32'h0);
        rd("mcyc_wrap_hi", 12'hB80, 32'h0);

        // minstret counts only retire strobes
        rd("minstret_idle", 12'hB02, 32'h7);
        @(negedge clk) bus.instret_inc_in = 1;
        repeat (3) @(posedge clk);
        @(negedge clk) bus.instret_inc_in = 0;
        #1;
        rd("minstret_plus3", 12'hB02, 32'hA);
        rd("minstreth_keep", 12'hB82, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
